// File: rtl/mouse_packet_fifo_io_if.sv
// Mouse packet FIFO bus bundle: packet strobe/data from the transceiver plus the processor
// address/control and interrupt lines. The tri-state data bus stays a plain module port.
interface mouse_packet_fifo_io_if #(
   parameter int unsigned NumFields = 4
) ();
   logic                   pkt_valid;
   logic [8*NumFields-1:0] pkt_data;
   logic [7:0]             bus_addr;
   logic                   bus_we;
   logic                   bus_irq_raise;
   logic [1:0]             bus_irq_ack;

   modport master (
      output pkt_valid, pkt_data, bus_addr, bus_we, bus_irq_ack,
      input  bus_irq_raise
   );

   modport slave (
      input  pkt_valid, pkt_data, bus_addr, bus_we, bus_irq_ack,
      output bus_irq_raise
   );
endinterface

// File: rtl/mouse_packet_fifo_io.sv
// Bus-mapped mouse peripheral: queues whole packets in a Depth-entry FIFO with software
// pop/flush/interrupt-enable control, an overflow flag and a registered tri-state read path.
module mouse_packet_fifo_io #(
   parameter logic [7:0]  BaseAddr  = 8'hA0,
   parameter int unsigned NumFields = 4,
   parameter int unsigned Depth     = 8,
   parameter int unsigned IrqBit    = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   mouse_packet_fifo_io_if.slave  bus_if,
   inout  wire  [7:0]             bus_data_io
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [8:0]  Base9 = {1'b0, BaseAddr};
   localparam logic [8:0]  StatOff = 9'(NumFields);
   localparam logic [8:0]  CtrlOff = 9'(NumFields + 1);

   logic [8*NumFields-1:0] mem_q [Depth];
   logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   ovf_q, ovf_d, ie_q, ie_d, irq_q, irq_d;
   logic                   oe_q, oe_d;
   logic [7:0]             dout_q, dout_d;

   logic [8:0] addr9, off;
   logic       empty, full, ctrl_wr, pop_req, flush, clr_ovf;
   logic       do_push, do_pop, drop, irq_set, rd_hit;
   logic [8*NumFields-1:0] head;
   logic [7:0] field_rd;

   assign addr9   = {1'b0, bus_if.bus_addr};
   assign off     = addr9 - Base9;
   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign ctrl_wr = bus_if.bus_we && (addr9 == Base9 + CtrlOff);
   assign pop_req = ctrl_wr && bus_data_io[1];
   assign flush   = ctrl_wr && bus_data_io[2];
   assign clr_ovf = ctrl_wr && bus_data_io[3];

   // A pop on a full FIFO frees the slot the same-cycle push lands in.
   assign do_pop  = pop_req && !empty && !flush;
   assign do_push = bus_if.pkt_valid && (!full || do_pop) && !flush;
   assign drop    = bus_if.pkt_valid && full && !do_pop && !flush;
   assign irq_set = ie_q && (do_push || (do_pop && (count_q > CntW'(1))));

   assign head = mem_q[rptr_q];
   assign rd_hit = !bus_if.bus_we && (addr9 >= Base9) && (addr9 <= Base9 + CtrlOff);

   always_comb begin
      field_rd = 8'h00;
      for (int unsigned i = 0; i < NumFields; i++) begin
         if (off == 9'(i)) field_rd = head[8*i +: 8];
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      ie_d    = ie_q;
      irq_d   = irq_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrW'(1);
         if (do_pop)  rptr_d = rptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
      if (ctrl_wr) ie_d = bus_data_io[0];
      if (flush) begin
         irq_d = 1'b0;
      end else if (irq_set) begin
         irq_d = 1'b1;
      end else if (bus_if.bus_irq_ack[IrqBit]) begin
         irq_d = 1'b0;
      end
   end

   always_comb begin
      oe_d   = rd_hit;
      dout_d = 8'h00;
      if (rd_hit) begin
         if (off < StatOff) begin
            dout_d = empty ? 8'h00 : field_rd;
         end else if (off == StatOff) begin
            dout_d = {ovf_q, full, empty, 5'(count_q)};
         end else begin
            dout_d = {7'b0, ie_q};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ie_q    <= 1'b0;
         irq_q   <= 1'b0;
         oe_q    <= 1'b0;
         dout_q  <= 8'h00;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ie_q    <= ie_d;
         irq_q   <= irq_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
      end
   end

   // Storage needs no reset: empty-FIFO reads are forced to zero.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= bus_if.pkt_data;
   end

   assign bus_if.bus_irq_raise = irq_q;
   assign bus_data_io = oe_q ? dout_q : 8'hzz;
endmodule

// File: doc/mouse_packet_fifo_io.md
# mouse_packet_fifo_io

Bus-mapped mouse peripheral for the microprocessor bus that queues complete mouse packets in a DEPTH-entry FIFO instead of exposing only the latest sample. It sits between the mouse transceiver (packet strobe plus field bytes) and the processor bus (BUS_DATA/BUS_ADDR/BUS_WE, interrupt raise/ack). It is generalised in packet width, queue depth, base address and interrupt line. It adds software pop, flush and interrupt-enable control, and an overflow flag.

## Interface
- BASE_ADDR, 8'hA0: address of field register 0.
- NUM_FIELDS, 4: bytes per packet, 1..8.
- DEPTH, 8: FIFO entries; power of two, 2..16.
- IRQ_BIT, 0: index into BUS_INTERRUPTS_ACK used as this block's ack.
- Constraint: BASE_ADDR+NUM_FIELDS+1 ≤ 8'hFF.
- CLK  in  1  single clock; all logic rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PKT_VALID  in  1  one-cycle strobe: packet complete.
- PKT_DATA  in  8*NUM_FIELDS  packet; field i = PKT_DATA[8i+7:8i].
- BUS_DATA  inout  8  processor data bus; Z unless this block reads out.
- BUS_ADDR  in  8  processor address.
- BUS_WE  in  1  1 = processor write.
- BUS_INTERRUPT_RAISE  out  1  level interrupt request.
- BUS_INTERRUPTS_ACK  in  2  interrupt acks; bit IRQ_BIT clears the request.

## Operation
- Address map, with offsets from BASE_ADDR:
  - 0..NUM_FIELDS-1: FIELD[i] of the head packet (R). Returns 8'h00 when the FIFO is empty.
  - NUM_FIELDS: STATUS (R) = {overflow, full, empty, count[4:0]}. count ranges 0..DEPTH.
  - NUM_FIELDS+1: CTRL.
    - Write bits, 1 = act: bit0 IE (stored), bit1 POP, bit2 FLUSH, bit3 CLR_OVF. Bits 1..3 are self-clearing strobes; bits 7:4 are ignored.
    - Read returns {7'b0, IE}.
- Push: PKT_VALID=1 and not full → entry at the write pointer ← PKT_DATA; write pointer +1 mod DEPTH; count +1.
- Push while full: the packet is dropped and overflow ← 1; the FIFO is unchanged.
- Pop (CTRL write with bit1=1) when not empty: read pointer +1 mod DEPTH; count −1. Pop when empty is ignored.
- Push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and no overflow is flagged.
  - When empty, only the push happens.
- FLUSH: pointers ← 0, count ← 0. It overrides a same-cycle push or pop; the discarded push does not set overflow.
- CLR_OVF: overflow ← 0. A same-cycle dropped push wins, so overflow stays 1.
- Interrupt pending flag (= BUS_INTERRUPT_RAISE):
  - Set when IE=1 and either a push is accepted, or a pop leaves count > 0.
  - Cleared by BUS_INTERRUPTS_ACK[IRQ_BIT]=1. When set and ack happen together, set wins.
  - Cleared by FLUSH.
  - Writing IE=0 does not clear a pending request.
- Read path: registered, one output register plus a drive-enable register.
  - Drive enable ← 1 iff BASE_ADDR ≤ BUS_ADDR ≤ BASE_ADDR+NUM_FIELDS+1 and BUS_WE=0.
  - Comparison is 9-bit, so there is no wrap above 8'hFF.
  - Out-of-range addresses never drive the bus.

## Timing
- Reset (RESET_N low, asynchronous) forces:
  - FIFO empty, pointers 0, overflow 0, IE 0.
  - BUS_INTERRUPT_RAISE 0, drive enable 0, output register 8'h00, BUS_DATA Z.
- Release is synchronised to CLK. Reset asserted mid-packet or mid-read discards everything immediately.
- Read: address sampled at edge k. BUS_DATA is valid from just after edge k until edge k+1, then returns to Z once the address leaves range. Data reflects state before edge k's updates.
- Write: BUS_ADDR/BUS_DATA/BUS_WE sampled at edge k; the effect is visible to a read sampled at edge k+1.
- Push at edge k: STATUS and FIELD reflect it for reads sampled at edge k+1 or later.
- Interrupt: a push at edge k with IE=1 raises BUS_INTERRUPT_RAISE after edge k. An ack sampled at edge m drops it after edge m.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then read BASE+NUM_FIELDS → 8'h20 (empty); FIELD0 → 8'h00; BUS_INTERRUPT_RAISE=0; BUS_DATA Z at address 8'h90.
- IE=1, push {8'h04,8'hFE,8'h12,8'h09} → IRQ high next cycle. FIELD0..3 read 09,12,FE,04; STATUS 8'h01. Ack → IRQ low. POP → STATUS 8'h20 and no re-raise.
- Push 9 packets with DEPTH=8 → STATUS 8'hC8; head is packet 1 and packet 9 is lost. CLR_OVF → 8'h48.
- Full FIFO, push and POP in the same cycle → count stays 8, overflow 0, head advances by one, new packet at the tail.
- Pending IRQ with a 3-entry FIFO: ack, then POP → IRQ re-raised (count 2). FLUSH together with PKT_VALID → count 0, IRQ low, overflow 0.
- Assert RESET_N low mid-read with 5 entries queued → BUS_DATA Z and STATUS 8'h20 after release.
